pipeline_n: RTL



---
 rtl/pipeline_pkg.sv | 11 +
 rtl/pipeline_slice.sv | 40 ++++
 rtl/pipeline_n.sv | 96 +++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the valid/ready register pipeline.
// Latency: n/a (package only).
// Backpressure: n/a; provides the occupancy counter width helper.
package pipeline_pkg;

   // Bits needed to represent 0..depth occupied slices.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipeline_slice.sv
// One pipeline register slice: a valid bit plus a data word with load enable.
// Latency: one clock edge from i_load to o_v/o_d.
// Backpressure: none locally; the parent decides when i_load is asserted.
// Ports: clk/rstn clock and async active-low reset; i_clr clears valid only;
//        i_load enables a load of i_v (and of i_d when i_v is set); o_v/o_d registered contents.
module pipeline_slice #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic             i_v,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_v,
   output logic [WIDTH-1:0] o_d
);

   logic             r_v;
   logic [WIDTH-1:0] r_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_v <= 1'b0;
         r_d <= '0;
      end else begin
         if (i_clr)
            r_v <= 1'b0;
         else if (i_load)
            r_v <= i_v;
         // Data only moves with a real word so an emptied slice keeps its last value.
         if (i_load && i_v)
            r_d <= i_d;
      end
   end

   assign o_v = r_v;
   assign o_d = r_d;

endmodule

// File: rtl/pipeline_n.sv
// DEPTH-slice valid/ready register pipeline with bubble collapsing, flush and occupancy count.
// Latency: word accepted at edge N reaches the output slice at edge N+DEPTH-1 (empty pipe).
// Backpressure: in_ready = an empty slot exists at or ahead of any stall; combinational from out_ready.
// Ports: clk/rstn; flush synchronous clear; in_valid/in_data/in_ready upstream;
//        out_valid/out_data/out_ready downstream (outputs registered); count occupied slices.
module pipeline_n
   import pipeline_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      flush,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   input  logic                      out_ready,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   localparam int CW = cnt_w(DEPTH);

   logic [DEPTH:0]   w_rdy;
   logic [DEPTH-1:0] w_v;
   logic [DEPTH-1:0] w_up_v;
   logic [DEPTH-1:0] w_v_nxt;
   logic [WIDTH-1:0] w_d    [DEPTH];
   logic [WIDTH-1:0] w_up_d [DEPTH];
   logic [CW-1:0]    w_cnt_nxt;
   logic [CW-1:0]    r_count;

   // Ready ripples from the output back: a slice can load if it is empty
   // or the slice ahead of it is also moving this cycle.
   always_comb begin
      w_rdy        = '0;
      w_rdy[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--)
         w_rdy[i] = ~w_v[i] | w_rdy[i+1];
   end

   assign in_ready = w_rdy[0] & ~flush & rstn;

   always_comb begin
      w_up_v    = '0;
      w_up_v[0] = in_valid & in_ready;
      for (int i = 1; i < DEPTH; i++)
         w_up_v[i] = w_v[i-1];
   end

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_slice
         if (g == 0) begin : g_head
            assign w_up_d[g] = in_data;
         end else begin : g_body
            assign w_up_d[g] = w_d[g-1];
         end

         pipeline_slice #(.WIDTH(WIDTH)) u_slice (
            .clk    (clk),
            .rstn   (rstn),
            .i_clr  (flush),
            .i_load (w_rdy[g]),
            .i_v    (w_up_v[g]),
            .i_d    (w_up_d[g]),
            .o_v    (w_v[g]),
            .o_d    (w_d[g])
         );
      end
   endgenerate

   // Mirror of the slices' next valid bits so count is registered in step with them.
   always_comb begin
      w_v_nxt   = '0;
      w_cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_v_nxt[i] = flush ? 1'b0 : (w_rdy[i] ? w_up_v[i] : w_v[i]);
         w_cnt_nxt  = w_cnt_nxt + CW'(w_v_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_count <= '0;
      else
         r_count <= w_cnt_nxt;
   end

   assign out_valid = w_v[DEPTH-1];
   assign out_data  = w_d[DEPTH-1];
   assign count     = r_count;

endmodule
